latch_arbiter: RTL and testbench

Round-robin controller that shares one `latch` capture stage among `NUM_REQ` requesters. Each granted request is sequenced through a full latch transaction: capture pulse, wait for valid, forward to the consumer, acknowledge. The response is tagged with the requester id. A watchdog flags a latch that never asserts valid. The block sits between the requester ports and the `latch` instance; it owns the latch's `latch`, `data_in` and `out_ack` inputs.

---
 rtl/latch_arbiter.sv | 175 +++++++++++++++++
 tb/tb_latch_arbiter.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_arbiter.sv
// latch_arbiter: round-robin sharing of a single latch capture stage among
// NUM_REQ requesters. Each grant runs one full latch transaction (capture,
// wait for valid, forward with requester id, acknowledge), guarded by a
// watchdog that drops the transaction if the latch never signals valid.
module latch_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic                          latch,
    output logic [DATA_WIDTH-1:0]         lat_data,
    input  logic                          lat_vld,
    input  logic [DATA_WIDTH-1:0]         lat_dout,
    output logic                          lat_ack,
    output logic                          rsp_vld,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]               rsp_id,
    input  logic                          rsp_ack,
    output logic                          busy,
    output logic                          timeout_err,
    input  logic                          err_clr
);

    // The counter only ever needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_VLD,
        S_RESP,
        S_WAIT_CLR
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ID_W-1:0]       ptr_q;
    logic [ID_W-1:0]       id_q;
    logic [ID_W-1:0]       winner;
    logic                  found;
    logic                  accept;
    logic                  fire;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  err_q;
    int                    scan_idx;

    // Requester index after v, wrapping at NUM_REQ (which need not be a power of two).
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        if (int'(v) == NUM_REQ - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!found && req_vld[scan_idx]) begin
                found  = 1'b1;
                winner = ID_W'(scan_idx);
            end
        end
    end

    assign accept = (state_q == S_IDLE) && found;

    // Next-state logic; the watchdog only fires when valid is still absent.
    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_VLD;
            end
            S_WAIT_VLD: begin
                if (lat_vld) begin
                    state_d = S_RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    fire    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                if (rsp_ack) begin
                    state_d = S_WAIT_CLR;
                end
            end
            S_WAIT_CLR: begin
                // Hold off until the latch drops valid so it is never forwarded twice.
                if (!lat_vld) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winner's id and payload and advance the round-robin pointer.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ptr_q  <= '0;
            id_q   <= '0;
            data_q <= '0;
        end else if (accept) begin
            ptr_q  <= wrap_inc(winner);
            id_q   <= winner;
            data_q <= req_data[int'(winner) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Watchdog counter: cleared while issuing, counts WAIT_VLD cycles without valid.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt_q <= '0;
        end else if (state_q == S_ISSUE) begin
            cnt_q <= '0;
        end else if (state_q == S_WAIT_VLD && !lat_vld) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            err_q <= 1'b0;
        end else if (fire) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    // req_rdy is combinational in IDLE and held low while reset is asserted.
    assign req_rdy     = (accept && !ap_rst) ? (NUM_REQ'(1) << winner) : '0;
    assign latch       = (state_q == S_ISSUE);
    assign lat_data    = data_q;
    assign rsp_vld     = (state_q == S_RESP);
    assign rsp_data    = lat_dout;
    assign rsp_id      = id_q;
    assign lat_ack     = rsp_vld && rsp_ack;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_latch_arbiter.sv
// Testbench for latch_arbiter: behavioural latch responder, queue-based
// scoreboard fed at grant time, and an independent response monitor.
module tb_latch_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int TIMEOUT    = 8;
    localparam int ID_W       = 2;

    logic                          ap_clk = 1'b0;
    logic                          ap_rst = 1'b1;
    logic [NUM_REQ-1:0]            req_vld = '0;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]            req_rdy;
    logic                          latch;
    logic [DATA_WIDTH-1:0]         lat_data;
    logic                          lat_vld;
    logic [DATA_WIDTH-1:0]         lat_dout;
    logic                          lat_ack;
    logic                          rsp_vld;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]               rsp_id;
    logic                          rsp_ack = 1'b0;
    logic                          busy;
    logic                          timeout_err;
    logic                          err_clr = 1'b0;

    latch_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .req_vld     (req_vld),
        .req_data    (req_data),
        .req_rdy     (req_rdy),
        .latch       (latch),
        .lat_data    (lat_data),
        .lat_vld     (lat_vld),
        .lat_dout    (lat_dout),
        .lat_ack     (lat_ack),
        .rsp_vld     (rsp_vld),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .rsp_ack     (rsp_ack),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 ap_clk = ~ap_clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int                    id;
        logic [DATA_WIDTH-1:0] data;
    } exp_t;
    exp_t sbq[$];

    int m_ptr      = 0;
    int lat_dly    = 1;
    bit lat_broken = 1'b0;
    int pend;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first requesting index at or after p, modulo NUM_REQ.
    function automatic int model_winner(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Latch responder: captures on strobe, raises valid lat_dly cycles later, drops on ack.
    always @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            lat_vld  <= 1'b0;
            lat_dout <= '0;
            pend     <= 0;
        end else begin
            if (lat_vld && lat_ack) lat_vld <= 1'b0;
            if (latch && !lat_broken) begin
                lat_dout <= lat_data;
                if (lat_dly <= 1) lat_vld <= 1'b1;
                else pend <= lat_dly - 1;
            end else if (pend != 0) begin
                pend <= pend - 1;
                if (pend == 1) lat_vld <= 1'b1;
            end
        end
    end

    // Called at a negedge with inputs applied: checks req_rdy against the model,
    // records the expected response, and returns the granted index (or -1).
    task automatic cycle(output int act);
        int                 w;
        logic [NUM_REQ-1:0] exp_rdy;
        act = -1;
        #1;
        if (!busy) begin
            w       = model_winner(req_vld, m_ptr);
            exp_rdy = (w < 0) ? '0 : (NUM_REQ'(1) << w);
            check("grant", req_rdy, exp_rdy);
            for (int i = 0; i < NUM_REQ; i++) if (req_rdy[i] && act < 0) act = i;
            if (w >= 0) begin
                if (!lat_broken) sbq.push_back('{w, req_data[w*DATA_WIDTH +: DATA_WIDTH]});
                m_ptr = (w + 1) % NUM_REQ;
            end
        end
        @(negedge ap_clk);
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        int a;
        n = 0;
        rsp_ack = 1'b1;
        while ((busy || req_vld != 0 || sbq.size() != 0) && n < budget) begin
            cycle(a);
            if (a >= 0) req_vld[a] = 1'b0;
            n++;
        end
        checks++;
        if (busy || req_vld != 0 || sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: busy=%0b req_vld=%b pending=%0d after %0d cycles, required idle with nothing pending", busy, req_vld, sbq.size(), n);
        end
    endtask

    task automatic wait_rsp(input int budget);
        int n;
        int a;
        n = 0;
        while (!rsp_vld && n < budget) begin
            cycle(a);
            if (a >= 0) req_vld[a] = 1'b0;
            n++;
        end
        checks++;
        if (!rsp_vld) begin
            errors++;
            $display("FAIL wait_rsp: rsp_vld=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic do_reset();
        ap_rst  = 1'b1;
        req_vld = '0;
        rsp_ack = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
        m_ptr  = 0;
        sbq.delete();
    endtask

    // Response monitor: pops the scoreboard on each accepted response and checks
    // stability under back-pressure, latch pulse width and the busy/ready exclusion.
    initial begin : monitor
        logic                  stall = 1'b0;
        logic                  prev_latch = 1'b0;
        logic [DATA_WIDTH-1:0] hold_data = '0;
        logic [ID_W-1:0]       hold_id = '0;
        exp_t                  e;
        forever begin
            @(negedge ap_clk);
            #2;
            if (ap_rst) begin
                stall      = 1'b0;
                prev_latch = 1'b0;
            end else begin
                if (latch) check("latch_width", prev_latch, 1'b0);
                prev_latch = latch;
                if (busy) check("rdy_while_busy", req_rdy, '0);
                if (rsp_vld) begin
                    check("lat_ack_follows", lat_ack, rsp_ack);
                    if (stall) begin
                        check("hold_data", rsp_data, hold_data);
                        check("hold_id", rsp_id, hold_id);
                    end
                    if (rsp_ack) begin
                        checks++;
                        if (sbq.size() == 0) begin
                            errors++;
                            $display("FAIL rsp_unexpected: got id=%0d data=%h, required no response", rsp_id, rsp_data);
                        end else begin
                            e = sbq.pop_front();
                            check("rsp_id", rsp_id, e.id);
                            check("rsp_data", rsp_data, e.data);
                        end
                    end
                end else begin
                    check("lat_ack_idle", lat_ack, 1'b0);
                end
                stall     = rsp_vld && !rsp_ack;
                hold_data = rsp_data;
                hold_id   = rsp_id;
            end
        end
    end

    initial begin : watchdog
        #500000;
        errors++;
        $display("FAIL global_timeout: still running at %0t, required completion", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int a;
        int k;
        int n;

        // Reset values
        @(negedge ap_clk);
        #1;
        check("rst_latch", latch, 1'b0);
        check("rst_lat_ack", lat_ack, 1'b0);
        check("rst_rsp_vld", rsp_vld, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_req_rdy", req_rdy, '0);
        check("rst_lat_data", lat_data, '0);
        check("rst_rsp_id", rsp_id, '0);
        @(negedge ap_clk);
        do_reset();

        // Single request with minimum latency
        lat_dly = 1;
        rsp_ack = 1'b1;
        req_data[0 +: DATA_WIDTH] = 32'hDEADBEEF;
        req_vld = 4'b0001;
        cycle(a);
        check("single_grant", a, 0);
        req_vld = '0;
        #1;
        check("single_latch_t1", latch, 1'b1);
        check("single_lat_data", lat_data, 32'hDEADBEEF);
        @(negedge ap_clk);
        #1;
        check("single_latch_t2", latch, 1'b0);
        check("single_rsp_t2", rsp_vld, 1'b0);
        @(negedge ap_clk);
        #1;
        check("single_rsp_vld_t3", rsp_vld, 1'b1);
        check("single_rsp_data", rsp_data, 32'hDEADBEEF);
        check("single_rsp_id", rsp_id, 0);
        check("single_lat_ack", lat_ack, 1'b1);
        @(negedge ap_clk);
        #1;
        check("single_busy_t4", busy, 1'b1);
        @(negedge ap_clk);
        #1;
        check("single_idle_t5", busy, 1'b0);
        check("single_lat_data_hold", lat_data, 32'hDEADBEEF);
        @(negedge ap_clk);

        // Round-robin fairness with every requester continuously valid
        do_reset();
        lat_dly = 1;
        rsp_ack = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_WIDTH +: DATA_WIDTH] = 32'h1000_0000 + i;
        req_vld = '1;
        k = 0;
        n = 0;
        while (k < 8 && n < 100) begin
            cycle(a);
            if (a >= 0) begin
                check("rr_order", a, k % NUM_REQ);
                req_data[a*DATA_WIDTH +: DATA_WIDTH] = 32'h2000_0000 + k * 16 + a;
                k++;
            end
            n++;
        end
        checks++;
        if (k < 8) begin
            errors++;
            $display("FAIL rr_count: got %0d grants, required 8", k);
        end
        req_vld = '0;
        run_until_idle(40);

        // Back-pressure: response held for 10 cycles while another requester waits
        rsp_ack = 1'b0;
        req_data[2*DATA_WIDTH +: DATA_WIDTH] = 32'hCAFE0002;
        req_vld = 4'b0100;
        cycle(a);
        check("bp_grant", a, 2);
        req_vld = 4'b0010;
        req_data[1*DATA_WIDTH +: DATA_WIDTH] = 32'hCAFE0001;
        wait_rsp(20);
        for (int c = 0; c < 10; c++) begin
            #1;
            check("bp_rsp_vld", rsp_vld, 1'b1);
            check("bp_rsp_data", rsp_data, 32'hCAFE0002);
            check("bp_rsp_id", rsp_id, 2);
            check("bp_lat_ack", lat_ack, 1'b0);
            check("bp_req_rdy", req_rdy, '0);
            @(negedge ap_clk);
        end
        run_until_idle(40);

        // Valid arriving on the last permitted WAIT_VLD cycle still completes
        lat_dly = TIMEOUT;
        req_data[0 +: DATA_WIDTH] = 32'h8888_0000;
        req_vld = 4'b0001;
        run_until_idle(60);
        #1;
        check("edge_no_timeout", timeout_err, 1'b0);
        @(negedge ap_clk);

        // Timeout with a dead latch
        lat_broken = 1'b1;
        rsp_ack = 1'b1;
        req_data[1*DATA_WIDTH +: DATA_WIDTH] = 32'h7777_0001;
        req_vld = 4'b0010;
        cycle(a);
        check("to_grant", a, 1);
        req_vld = '0;
        repeat (TIMEOUT) @(negedge ap_clk);
        #1;
        check("to_busy_last_wait", busy, 1'b1);
        check("to_err_before", timeout_err, 1'b0);
        @(negedge ap_clk);
        #1;
        check("to_err_set", timeout_err, 1'b1);
        check("to_back_idle", busy, 1'b0);
        @(negedge ap_clk);
        lat_broken = 1'b0;
        lat_dly = 2;
        req_data[3*DATA_WIDTH +: DATA_WIDTH] = 32'h5A5A_0003;
        req_vld = 4'b1000;
        run_until_idle(40);
        #1;
        check("to_err_sticky", timeout_err, 1'b1);
        @(negedge ap_clk);
        err_clr = 1'b1;
        @(negedge ap_clk);
        err_clr = 1'b0;
        #1;
        check("to_err_cleared", timeout_err, 1'b0);
        @(negedge ap_clk);

        // Timeout coinciding with err_clr: set wins
        lat_broken = 1'b1;
        err_clr = 1'b1;
        req_vld = 4'b0001;
        cycle(a);
        req_vld = '0;
        repeat (TIMEOUT) @(negedge ap_clk);
        @(negedge ap_clk);
        #1;
        check("to_set_wins", timeout_err, 1'b1);
        err_clr = 1'b0;
        @(negedge ap_clk);
        #1;
        check("to_set_hold", timeout_err, 1'b1);
        @(negedge ap_clk);
        err_clr = 1'b1;
        @(negedge ap_clk);
        err_clr = 1'b0;
        lat_broken = 1'b0;
        #1;
        check("to_err_cleared2", timeout_err, 1'b0);
        @(negedge ap_clk);

        // Asynchronous reset while in RESP
        rsp_ack = 1'b0;
        lat_dly = 1;
        req_data[1*DATA_WIDTH +: DATA_WIDTH] = 32'h0BAD_0001;
        req_vld = 4'b0010;
        cycle(a);
        req_vld = '0;
        wait_rsp(20);
        rsp_ack = 1'b1;
        #1;
        check("mid_rst_lat_ack_before", lat_ack, 1'b1);
        ap_rst = 1'b1;
        #1;
        check("mid_rst_rsp_vld", rsp_vld, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_lat_ack", lat_ack, 1'b0);
        check("mid_rst_ptr", dut.ptr_q, 0);
        sbq.delete();
        m_ptr = 0;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        req_data[0 +: DATA_WIDTH] = 32'h0000_1110;
        req_data[2*DATA_WIDTH +: DATA_WIDTH] = 32'h0000_3332;
        req_vld = 4'b0101;
        cycle(a);
        check("post_rst_first", a, 0);
        req_vld[0] = 1'b0;
        run_until_idle(40);

        // Sparse request from requester 3 with ptr=1
        do_reset();
        lat_dly = 1;
        req_data[0 +: DATA_WIDTH] = 32'h0101_0101;
        req_vld = 4'b0001;
        run_until_idle(30);
        check("sparse_ptr_before", dut.ptr_q, 1);
        req_data[3*DATA_WIDTH +: DATA_WIDTH] = 32'h3030_3030;
        req_vld = 4'b1000;
        cycle(a);
        check("sparse_grant", a, 3);
        req_vld[3] = 1'b0;
        check("sparse_ptr_after", dut.ptr_q, 0);
        run_until_idle(30);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_vld[i] && $urandom_range(3) == 0) begin
                    req_vld[i] = 1'b1;
                    req_data[i*DATA_WIDTH +: DATA_WIDTH] = $urandom;
                end
            end
            rsp_ack = ($urandom_range(3) != 0);
            lat_dly = $urandom_range(1, TIMEOUT);
            cycle(a);
            if (a >= 0) req_vld[a] = 1'b0;
        end
        run_until_idle(100);
        #1;
        check("rand_no_timeout", timeout_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
